// File: rtl/reset_pkg.sv
// ---------------------------------------------------------------------------
// reset_pkg
// Shared definitions for the staged reset release controller.
//   rst_seq_state_e : sequencer state encoding (HOLD, RUN, SWRST)
//   cnt_width()     : width of a counter that must hold values 0..delay
// ---------------------------------------------------------------------------
package reset_pkg;

    typedef enum logic [1:0] {
        HOLD  = 2'd0,
        RUN   = 2'd1,
        SWRST = 2'd2
    } rst_seq_state_e;

    function automatic int cnt_width(input int delay);
        return $clog2(delay + 1);
    endfunction

endpackage

// File: rtl/reset_delay_counter.sv
// ---------------------------------------------------------------------------
// reset_delay_counter
// Free-running gap counter used by the reset sequencer. It counts enabled
// cycles and flags the terminal count at STAGE_DELAY-1, then wraps to zero
// on its own.
// Ports:
//   clk_i  : clock, rising edge
//   rstn_i : asynchronous active-low reset
//   clear  : synchronous clear, has priority over enable
//   enable : advance the count this cycle
//   tc     : high while the count equals STAGE_DELAY-1
// ---------------------------------------------------------------------------
module reset_delay_counter
    import reset_pkg::*;
#(
    parameter int STAGE_DELAY = 16
) (
    input  logic clk_i,
    input  logic rstn_i,
    input  logic clear,
    input  logic enable,
    output logic tc
);

    localparam int CNT_W = cnt_width(STAGE_DELAY);
    localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(STAGE_DELAY - 1);

    logic [CNT_W-1:0] cnt;

    // Wrapping at the terminal count lets the next gap start without an
    // explicit clear from the sequencer.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable) begin
            if (cnt == TC_VAL) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    assign tc = (cnt == TC_VAL);

endmodule

// File: rtl/reset_sequencer.sv
// ---------------------------------------------------------------------------
// reset_sequencer
// Releases N_STAGES subsystem resets one after another, STAGE_DELAY cycles
// apart, after the synchronized system reset deasserts. A warm-reset request
// in RUN re-asserts every stage, holds for STAGE_DELAY cycles, pulses an
// acknowledge and replays the release sequence.
// Parameters:
//   N_STAGES    : number of sequenced resets (1..8)
//   STAGE_DELAY : cycles between releases and warm-reset hold length (>=1)
// Ports:
//   clk_i        : clock, rising edge
//   rstn_i       : asynchronous active-low reset (already synchronized)
//   sw_rst_req_i : warm-reset request, level-sampled, honoured only in RUN
//   sw_rst_ack_o : one-cycle pulse at the end of the warm-reset hold
//   rstn_stage_o : sequenced active-low resets, bit 0 released first
//   done_o       : high while every stage is released
// ---------------------------------------------------------------------------
module reset_sequencer
    import reset_pkg::*;
#(
    parameter int N_STAGES    = 3,
    parameter int STAGE_DELAY = 16
) (
    input  logic                clk_i,
    input  logic                rstn_i,
    input  logic                sw_rst_req_i,
    output logic                sw_rst_ack_o,
    output logic [N_STAGES-1:0] rstn_stage_o,
    output logic                done_o
);

    localparam int IDX_W = $clog2(N_STAGES + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_STAGES - 1);

    rst_seq_state_e      state;
    rst_seq_state_e      state_next;
    logic [IDX_W-1:0]    idx;
    logic [IDX_W-1:0]    idx_next;
    logic [N_STAGES-1:0] stage;
    logic [N_STAGES-1:0] stage_next;
    logic                done;
    logic                done_next;
    logic                ack;
    logic                ack_next;

    logic                cnt_clear;
    logic                cnt_en;
    logic                cnt_tc;

    reset_delay_counter #(
        .STAGE_DELAY(STAGE_DELAY)
    ) u_delay (
        .clk_i  (clk_i),
        .rstn_i (rstn_i),
        .clear  (cnt_clear),
        .enable (cnt_en),
        .tc     (cnt_tc)
    );

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state <= HOLD;
            idx   <= '0;
            stage <= '0;
            done  <= 1'b0;
            ack   <= 1'b0;
        end else begin
            state <= state_next;
            idx   <= idx_next;
            stage <= stage_next;
            done  <= done_next;
            ack   <= ack_next;
        end
    end

    always_comb begin
        state_next = state;
        idx_next   = idx;
        stage_next = stage;
        done_next  = done;
        ack_next   = 1'b0;
        cnt_clear  = 1'b0;
        cnt_en     = 1'b0;

        case (state)
            HOLD: begin
                cnt_en = 1'b1;
                if (cnt_tc) begin
                    // Only the stage selected by idx is set; bits already
                    // released keep their value so stages stay monotonic.
                    for (int i = 0; i < N_STAGES; i++) begin
                        if (idx == IDX_W'(i)) begin
                            stage_next[i] = 1'b1;
                        end
                    end
                    idx_next = idx + IDX_W'(1);
                    if (idx == LAST_IDX) begin
                        state_next = RUN;
                        done_next  = 1'b1;
                    end
                end
            end

            RUN: begin
                stage_next = '1;
                done_next  = 1'b1;
                cnt_clear  = 1'b1;
                if (sw_rst_req_i) begin
                    stage_next = '0;
                    done_next  = 1'b0;
                    idx_next   = '0;
                    state_next = SWRST;
                end
            end

            SWRST: begin
                cnt_en     = 1'b1;
                stage_next = '0;
                done_next  = 1'b0;
                if (cnt_tc) begin
                    ack_next   = 1'b1;
                    state_next = HOLD;
                end
            end

            default: begin
                // Unused encoding: restart the release sequence from scratch.
                state_next = HOLD;
                stage_next = '0;
                done_next  = 1'b0;
                idx_next   = '0;
                cnt_clear  = 1'b1;
            end
        endcase
    end

    assign rstn_stage_o = stage;
    assign done_o       = done;
    assign sw_rst_ack_o = ack;

endmodule
